// File: rtl/usb_crc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_crc_pkg
//  Description : Shared types and constants for the USB serial CRC engine.
//                Holds the engine state encoding plus the CRC5 (token) and
//                CRC16 (data) polynomials and their good-frame residuals.
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_crc_pkg;

   // Engine state encoding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SEND  = 2'd2,
      DONE  = 2'd3
   } crc_state_t;

   // Generator polynomials without the implicit x^WIDTH term
   localparam logic [4:0]  CRC5_POLY      = 5'h05;
   localparam logic [15:0] CRC16_POLY     = 16'h8005;

   // Register contents after a good frame followed by its complemented CRC
   localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
   localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

endpackage : usb_crc_pkg
`default_nettype wire

// File: rtl/crc_lfsr_step.sv
`default_nettype none
// ============================================================================
//  Module      : crc_lfsr_step
//  Description : Combinational one-bit CRC update. Given the current register
//                and one serial bit (MSB-first shift, Galois form), produces
//                the next register value.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_lfsr_step
   import usb_crc_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(CRC16_POLY)
) (
   input  logic [WIDTH-1:0] i_crc,
   input  logic             i_bit,
   output logic [WIDTH-1:0] o_crc
);

   logic w_fb;

   // Feedback is the incoming bit against the register MSB about to leave
   assign w_fb  = i_bit ^ i_crc[WIDTH-1];
   assign o_crc = {i_crc[WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : {WIDTH{1'b0}});

endmodule : crc_lfsr_step
`default_nettype wire

// File: rtl/crc_serial_engine.sv
`default_nettype none
// ============================================================================
//  Module      : crc_serial_engine
//  Description : Parametrised serial CRC generator/checker for USB TX and RX.
//                TX: accumulate the bit stream, then on send_req shift out the
//                complemented remainder MSB-first under a tx_ready handshake.
//                RX: accumulate payload plus received CRC; crc_ok flags that
//                the register holds the good-frame residual.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_serial_engine
   import usb_crc_pkg::*;
#(
   parameter int               WIDTH    = 16,
   parameter logic [15:0]      POLY     = CRC16_POLY,
   parameter logic [WIDTH-1:0] INIT     = {WIDTH{1'b1}},
   parameter logic [15:0]      RESIDUAL = CRC16_RESIDUAL
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             data_in,
   input  logic             data_valid,
   input  logic             send_req,
   input  logic             tx_ready,
   output logic [WIDTH-1:0] crc_value,
   output logic             crc_ser,
   output logic             crc_ser_valid,
   output logic             crc_done,
   output logic             crc_ok
);

   localparam int               CW     = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]    C_LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] C_POLY = POLY[WIDTH-1:0];
   localparam logic [WIDTH-1:0] C_RES  = RESIDUAL[WIDTH-1:0];

   crc_state_t       r_state;
   logic [WIDTH-1:0] r_crc;
   logic [CW-1:0]    r_count;
   logic             r_valid;
   logic             r_done;
   logic             r_ok;

   crc_state_t       w_state_nxt;
   logic [WIDTH-1:0] w_crc_nxt;
   logic [CW-1:0]    w_count_nxt;
   logic [WIDTH-1:0] w_step;

   crc_lfsr_step #(
      .WIDTH (WIDTH),
      .POLY  (C_POLY)
   ) u_step (
      .i_crc (r_crc),
      .i_bit (data_in),
      .o_crc (w_step)
   );

   // Next-state, next-register and next-count decode for the engine
   always_comb begin
      w_state_nxt = r_state;
      w_crc_nxt   = r_crc;
      w_count_nxt = r_count;
      case (r_state)
         IDLE, ACCUM: begin
            // A bit arriving with send_req is absorbed before shift-out
            if (data_valid) begin
               w_crc_nxt = w_step;
            end
            if (send_req) begin
               w_state_nxt = SEND;
            end else if (data_valid) begin
               w_state_nxt = ACCUM;
            end
         end
         SEND: begin
            // Without tx_ready everything holds; there is no timeout
            if (tx_ready) begin
               w_crc_nxt   = {r_crc[WIDTH-2:0], 1'b0};
               w_count_nxt = r_count + CW'(1);
               if (r_count == C_LAST) begin
                  w_state_nxt = DONE;
               end
            end
         end
         DONE: begin
            w_crc_nxt   = INIT;
            w_count_nxt = '0;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
            w_crc_nxt   = INIT;
            w_count_nxt = '0;
         end
      endcase
   end

   // State, CRC register, counter and registered status outputs
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= IDLE;
         r_crc   <= INIT;
         r_count <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_ok    <= 1'b0;
      end else if (clear) begin
         r_state <= IDLE;
         r_crc   <= INIT;
         r_count <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_ok    <= (INIT == C_RES);
      end else begin
         r_state <= w_state_nxt;
         r_crc   <= w_crc_nxt;
         r_count <= w_count_nxt;
         r_valid <= (w_state_nxt == SEND);
         r_done  <= (w_state_nxt == DONE);
         // Compared on the next value so crc_ok always tracks crc_value
         r_ok    <= (w_crc_nxt == C_RES);
      end
   end

   assign crc_value     = r_crc;
   assign crc_ser       = ~r_crc[WIDTH-1];
   assign crc_ser_valid = r_valid;
   assign crc_done      = r_done;
   assign crc_ok        = r_ok;

endmodule : crc_serial_engine
`default_nettype wire
